// File: rtl/rv32_decode_pkg.sv
// ---------------------------------------------------------------------------
// rv32_decode_pkg
// Shared decode definitions for the stage-2 decode controller: RV32I major
// opcodes, the one-entry pipeline register state encoding, and small helpers
// that say which source registers an opcode actually reads.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_decode_pkg;

    // RV32I major opcodes (instr[6:0]) that the decode stage cares about
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Saturation value of the load-use bubble counter
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Occupancy of the single decode entry
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // rs1 is read by everything except the formats that have no rs1 field
    function automatic logic usesRs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    // rs2 is only read by stores, branches and register-register ALU ops
    function automatic logic usesRs2(input logic [6:0] opcode);
        return (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_REG);
    endfunction

endpackage : rv32_decode_pkg

// File: rtl/stage2_decode_ctrl_imm_extract.sv
// ---------------------------------------------------------------------------
// imm_extract
// Purely combinational RV32I immediate generator. Produces the sign-extended
// immediate for I/load, S, B and J formats, the upper immediate for U, and
// zero for every other opcode.
// Ports:
//   i_instr  in  32  raw instruction word
//   o_imm    out 32  decoded immediate
// ---------------------------------------------------------------------------
module imm_extract
    import rv32_decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    logic [6:0] w_opcode;
    assign w_opcode = i_instr[6:0];

    // Format select on the major opcode. B and J immediates are halfword
    // offsets, so their bit 0 is always zero.
    always_comb begin
        o_imm = '0;
        case (w_opcode)
            OP_IMM, OP_LOAD:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            OP_STORE:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OP_BRANCH:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                o_imm = {i_instr[31:12], 12'b0};
            OP_JAL:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule : imm_extract

// File: rtl/stage2_decode_ctrl.sv
// ---------------------------------------------------------------------------
// stage2_decode_ctrl
// One-entry decode pipeline register between fetch and execute. Captures the
// instruction, PC, register specifiers and immediate on accept, offers the
// entry to execute, supports back-to-back streaming, flush on redirect and
// (optionally) a load-use interlock with a saturating bubble counter.
//
// Optional feature: define STAGE2_LOAD_USE_INTERLOCK_EN to compile in the
// load-use hazard detection and stall counter. Without it the hazard is
// constant 0, ex_is_load/ex_rd are ignored and stall_cnt stays 0.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   if_valid     in   1   fetch presents an instruction
//   if_instr     in  32   fetched instruction
//   if_pc        in  32   PC of if_instr
//   if_ready     out  1   decode accepts if_instr this cycle
//   id_valid     out  1   decoded entry offered to execute
//   id_instr     out 32   registered instruction
//   id_pc        out 32   registered PC
//   id_imm       out 32   registered immediate
//   id_rs1/2/rd  out  5   registered register specifiers
//   ex_ready     in   1   execute accepts the entry
//   ex_is_load   in   1   instruction in execute is a load
//   ex_rd        in   5   destination of the instruction in execute
//   flush        in   1   discard held entry and any concurrent fetch
//   stall_cnt    out 16   saturating count of load-use bubble cycles
// ---------------------------------------------------------------------------
module stage2_decode_ctrl
    import rv32_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    input  logic        ex_ready,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic [15:0] stall_cnt
);

    state_e      r_state;
    state_e      w_stateNext;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] w_imm;
    logic        w_hazard;
    logic        w_idValid;
    logic        w_leave;
    logic        w_ifReady;
    logic        w_accept;

    // Immediate is decoded from the incoming word so it can be registered
    // alongside the instruction on accept.
    imm_extract u_imm_extract (
        .i_instr (if_instr),
        .o_imm   (w_imm)
    );

`ifdef STAGE2_LOAD_USE_INTERLOCK_EN
    logic [6:0]  w_opcode;
    logic        w_rs1Hit;
    logic        w_rs2Hit;
    logic [15:0] r_stallCnt;

    assign w_opcode = r_instr[6:0];
    assign w_rs1Hit = (ex_rd == r_rs1) && usesRs1(w_opcode);
    assign w_rs2Hit = (ex_rd == r_rs2) && usesRs2(w_opcode);

    // x0 is never a real dependency, so a load targeting x0 never stalls.
    assign w_hazard = (r_state == ST_FULL) && ex_is_load && (ex_rd != 5'd0)
                      && (w_rs1Hit || w_rs2Hit);

    // Bubble counter: a flushed cycle is not a bubble since the entry is
    // being thrown away anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stallCnt <= '0;
        end else if (w_hazard && !flush && (r_stallCnt != STALL_MAX)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`else
    logic w_unused;

    assign w_unused  = ^{ex_is_load, ex_rd};
    assign w_hazard  = 1'b0;
    assign stall_cnt = '0;
`endif

    // Handshake terms. Flush dominates everything: it hides the entry from
    // execute and refuses fetch in the same cycle.
    assign w_idValid = (r_state == ST_FULL) && !w_hazard && !flush;
    assign w_leave   = w_idValid && ex_ready;
    assign w_ifReady = !flush && ((r_state == ST_EMPTY) || w_leave);
    assign w_accept  = if_valid && w_ifReady;

    assign id_valid  = w_idValid;
    assign if_ready  = w_ifReady;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: accept keeps/makes the stage full even when the old entry
    // leaves in the same cycle, which gives bubble-free streaming.
    always_comb begin
        w_stateNext = r_state;
        if (flush) begin
            w_stateNext = ST_EMPTY;
        end else if (w_accept) begin
            w_stateNext = ST_FULL;
        end else if (w_leave) begin
            w_stateNext = ST_EMPTY;
        end
    end

    // Data registers only move on accept; going empty leaves them as-is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else if (w_accept) begin
            r_instr <= if_instr;
            r_pc    <= if_pc;
            r_imm   <= w_imm;
            r_rs1   <= if_instr[19:15];
            r_rs2   <= if_instr[24:20];
            r_rd    <= if_instr[11:7];
        end
    end

    assign id_instr = r_instr;
    assign id_pc    = r_pc;
    assign id_imm   = r_imm;
    assign id_rs1   = r_rs1;
    assign id_rs2   = r_rs2;
    assign id_rd    = r_rd;

endmodule : stage2_decode_ctrl

// File: tb/tb_stage2_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stage2_decode_ctrl
// Directed bench for stage2_decode_ctrl. Stimulus pushes the expected
// contents of every entry that should reach execute into a queue; a monitor
// pops and compares on each id_valid/ex_ready handshake. Cycle-level flags
// (id_valid, if_ready, stall_cnt, held data) are checked from the stimulus.
// Expectations follow STAGE2_LOAD_USE_INTERLOCK_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_stage2_decode_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
    } exp_t;

`ifdef STAGE2_LOAD_USE_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        ex_ready;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic [15:0] stall_cnt;

    int   nChecks = 0;
    int   nPass   = 0;
    exp_t expQ[$];
    exp_t monExp;

    // Streaming table: addi x5,x0,5 / lui x6,0x12345 / sw x5,8(x6) /
    // beq x1,x2,-4 / jal x1,-8
    logic [31:0] sInstr [5] = '{32'h00500293, 32'h12345337, 32'h00532423,
                                32'hFE208EE3, 32'hFF9FF0EF};
    logic [31:0] sImm   [5] = '{32'h00000005, 32'h12345000, 32'h00000008,
                                32'hFFFFFFFC, 32'hFFFFFFF8};
    logic [4:0]  sRd    [5] = '{5'd5, 5'd6, 5'd8, 5'd29, 5'd1};

    stage2_decode_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_imm     (id_imm),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .ex_ready   (ex_ready),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic exr,
                                 input logic load, input logic [4:0] exrd,
                                 input logic fl);
        if_valid   = v;
        if_instr   = instr;
        if_pc      = pc;
        ex_ready   = exr;
        ex_is_load = load;
        ex_rd      = exrd;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectHs(input string name, input logic expValid,
                            input logic expReady);
        checkOutput({name, "_id_valid"}, {31'b0, id_valid}, {31'b0, expValid});
        checkOutput({name, "_if_ready"}, {31'b0, if_ready}, {31'b0, expReady});
    endtask

    task automatic pushExp(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [4:0] rd);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.imm   = imm;
        e.rd    = rd;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_id_valid"}, {31'b0, id_valid}, 32'd0);
        checkOutput({name, "_id_instr"}, id_instr, 32'd0);
        checkOutput({name, "_id_pc"}, id_pc, 32'd0);
        checkOutput({name, "_id_imm"}, id_imm, 32'd0);
        checkOutput({name, "_id_regs"}, {17'b0, id_rs1, id_rs2, id_rd}, 32'd0);
        checkOutput({name, "_stall_cnt"}, {16'b0, stall_cnt}, 32'd0);
    endtask

    // Monitor: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (reset_n && id_valid && ex_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL mon_unexpected: got instr %h, expected no entry", id_instr);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("mon_instr", id_instr, monExp.instr);
                checkOutput("mon_pc", id_pc, monExp.pc);
                checkOutput("mon_imm", id_imm, monExp.imm);
                checkOutput("mon_rd", {27'b0, id_rd}, {27'b0, monExp.rd});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        checkAllZero("reset");
        #10;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // addi x1,x0,-1 straight through
        applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0);
        pushExp(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 5'd1);
        @(negedge clk); expectHs("s1_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s1_out", 1'b1, 1'b1);
        checkOutput("s1_imm", id_imm, 32'hFFFFFFFF);
        checkOutput("s1_rd", {27'b0, id_rd}, 32'd1);
        tick();

        // Back-to-back streaming, one entry per cycle, no bubble
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, sInstr[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0, 5'd0, 1'b0);
            pushExp(sInstr[i], 32'h200 + 32'(4 * i), sImm[i], sRd[i]);
            @(negedge clk); expectHs("s2_stream", (i > 0), 1'b1); tick();
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk); expectHs("s2_drain", 1'b1, 1'b1); tick();
        @(negedge clk); expectHs("s2_idle", 1'b0, 1'b1); tick();

        // add x3,x1,x2 held against a load to x2 for two cycles
        applyStimulus(1'b1, 32'h002081B3, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0);
        pushExp(32'h002081B3, 32'h300, 32'h0, 5'd3);
        @(negedge clk); expectHs("s3_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd2, 1'b0);
        @(negedge clk); expectHs("s3_haz1", !IL, !IL); tick();
        @(negedge clk); expectHs("s3_haz2", 1'b0, !IL); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s3_release", IL, 1'b1);
        checkOutput("s3_stall_cnt", {16'b0, stall_cnt}, IL ? 32'd2 : 32'd0);
        tick();

        // Load to x0 is never a dependency
        applyStimulus(1'b1, 32'h002081B3, 32'h304, 1'b1, 1'b0, 5'd0, 1'b0);
        pushExp(32'h002081B3, 32'h304, 32'h0, 5'd3);
        @(negedge clk); expectHs("s4_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s4_x0", 1'b1, 1'b1);
        checkOutput("s4_stall_cnt", {16'b0, stall_cnt}, IL ? 32'd2 : 32'd0);
        tick();

        // LUI has an rs1 field of 8 but does not read it
        applyStimulus(1'b1, 32'h12345337, 32'h308, 1'b1, 1'b0, 5'd0, 1'b0);
        pushExp(32'h12345337, 32'h308, 32'h12345000, 5'd6);
        @(negedge clk); expectHs("s4_lui_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd8, 1'b0);
        @(negedge clk); expectHs("s4_lui", 1'b1, 1'b1); tick();

        // sw x5,8(x6) stalls one cycle on rs1 = x6
        applyStimulus(1'b1, 32'h00532423, 32'h30C, 1'b1, 1'b0, 5'd0, 1'b0);
        pushExp(32'h00532423, 32'h30C, 32'h8, 5'd8);
        @(negedge clk); expectHs("s4_sw_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd6, 1'b0);
        @(negedge clk); expectHs("s4_sw_haz", !IL, !IL); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s4_sw_rel", IL, 1'b1);
        checkOutput("s4_sw_stall_cnt", {16'b0, stall_cnt}, IL ? 32'd3 : 32'd0);
        tick();

        // Held entry with execute busy, then flush with a competing fetch
        applyStimulus(1'b1, 32'h00500293, 32'h400, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); expectHs("s5_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s5_hold", 1'b1, 1'b0);
        checkOutput("s5_hold_instr", id_instr, 32'h00500293);
        tick();
        applyStimulus(1'b1, 32'h12345337, 32'h404, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk); expectHs("s5_flush", 1'b0, 1'b0); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s5_after", 1'b0, 1'b1);
        checkOutput("s5_instr_kept", id_instr, 32'h00500293);
        checkOutput("s5_pc_kept", id_pc, 32'h400);
        tick();

        // Asynchronous reset while full
        applyStimulus(1'b1, 32'hFF9FF0EF, 32'h500, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); expectHs("s6_acc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        expectHs("s6_full", 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("s6_reset");
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        applyStimulus(1'b1, 32'hFFF00093, 32'h600, 1'b1, 1'b0, 5'd0, 1'b0);
        pushExp(32'hFFF00093, 32'h600, 32'hFFFFFFFF, 5'd1);
        @(negedge clk); expectHs("s6_reacc", 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk); expectHs("s6_out", 1'b1, 1'b1); tick();
        tick();

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule : tb_stage2_decode_ctrl

// File: doc/stage2_decode_ctrl.md
STAGE2_DECODE_CTRL -- requirements
Module: stage2_decode_ctrl

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  fetched instruction
- if_pc  in  32  PC of if_instr
- if_ready  out  1  decode stage accepts if_instr this cycle
- id_valid  out  1  decoded entry offered to execute
- id_instr  out  32  registered instruction
- id_pc  out  32  registered PC
- id_imm  out  32  registered immediate, RV32I I/S/B/U/J formats
- id_rs1, id_rs2, id_rd  out  5 each  registered instr[19:15], [24:20], [11:7]
- ex_ready  in  1  execute accepts the id entry
- ex_is_load  in  1  instruction now in execute is a load
- ex_rd  in  5  destination of the instruction in execute
- flush  in  1  discard the held entry (branch/jump redirect)
- stall_cnt  out  16  saturating count of load-use bubble cycles

Function
REQ-002 The block SHALL be a one-entry pipeline register with states EMPTY and FULL.
REQ-003 hazard SHALL be asserted when state is FULL, ex_is_load=1, ex_rd!=0, and either (ex_rd==id_rs1 and opcode uses rs1) or (ex_rd==id_rs2 and opcode uses rs2).
REQ-004 rs1 SHALL count as used for every opcode except 0110111, 0010111, 1101111; rs2 only for 0100011, 1100011, 0110011.
REQ-005 id_valid SHALL equal (state==FULL) AND NOT hazard AND NOT flush.
REQ-006 The entry SHALL leave when id_valid=1 and ex_ready=1.
REQ-007 if_ready SHALL equal NOT flush AND (state==EMPTY OR entry leaves this cycle).
REQ-008 On if_valid AND if_ready, the block SHALL load id_instr, id_pc, id_rs1/rs2/rd and id_imm, and state SHALL be FULL next cycle; accept-to-id_valid latency is 1 cycle.
REQ-009 id_imm SHALL be sign-extended from instr[31] for I/load, S, B (bit0=0) and J (bit0=0); U SHALL be {instr[31:12],12'b0}; all other opcodes SHALL give 0.
REQ-010 If the entry leaves and no new instruction is accepted, state SHALL become EMPTY; leave plus accept in the same cycle SHALL keep FULL with the new entry (back-to-back, no bubble).
REQ-011 With FULL, no hazard and ex_ready=0, all id_* outputs SHALL hold unchanged.
REQ-012 Hazard SHALL block the entry and if_ready for every cycle it is asserted; the entry SHALL be offered again in the first cycle hazard deasserts.
REQ-013 flush=1 SHALL force state EMPTY next cycle, discard the held entry and any concurrent if_valid; flush has priority over accept, leave and hazard.
REQ-014 stall_cnt SHALL increment by 1 on each cycle with hazard=1 and flush=0, saturating at 16'hFFFF.
REQ-015 Data outputs SHALL update only on accept; EMPTY SHALL not clear them.

Reset
REQ-016 On reset_n=0, state SHALL be EMPTY, and id_valid, id_instr, id_pc, id_imm, id_rs1, id_rs2, id_rd and stall_cnt SHALL all be 0, asynchronously.
REQ-017 Reset asserted mid-operation SHALL drop the held entry; the first accept after release SHALL behave as from idle.

Configuration
REQ-018 Macro STAGE2_LOAD_USE_INTERLOCK_EN SHALL compile in the hazard logic of REQ-003/004/012/014.
REQ-019 Without the macro, hazard SHALL be constant 0, ex_is_load and ex_rd SHALL remain ports but be ignored, and stall_cnt SHALL stay 0.

Structure
REQ-020 Opcode constants (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG) and the state encoding SHALL live in shared package rv32_decode_pkg.
REQ-021 Immediate extraction SHALL be a combinational sub-module imm_extract, driven by if_instr and registered in this block.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- reset, then if_instr=32'hFFF00093 (addi x1,x0,-1), ex_ready=1 -> next cycle id_valid=1, id_imm=32'hFFFFFFFF, id_rd=1.
- streaming 3 instructions with ex_ready=1 -> one instruction leaves per cycle, if_ready stays 1, no bubble.
- held add x3,x1,x2 with ex_is_load=1, ex_rd=2 for 2 cycles -> id_valid=0 and if_ready=0 for 2 cycles, stall_cnt=2, then id_valid=1.
- same hazard with ex_rd=0 -> no stall, stall_cnt unchanged.
- FULL with ex_ready=0, flush=1 and if_valid=1 -> next cycle state EMPTY, id_valid=0, incoming instruction not captured.
- reset_n pulsed low while FULL -> all outputs 0 immediately; the macro-off build with a forced hazard pattern -> no stalls, stall_cnt=0.
